// File: rtl/prio_rr_scheduler_if.sv
// prio_rr_scheduler_if: snapshot load, flag clear and valid/ready grant signals for the scheduler
interface prio_rr_scheduler_if #(
   parameter int PORTNUM = 16,
   parameter int PRIOR   = 8
);
   localparam int IW = $clog2(PORTNUM);
   localparam int PW = $clog2(PRIOR);
   logic [PORTNUM-1:0]    i_pending;
   logic [PORTNUM*PW-1:0] i_prior;
   logic                  i_update;
   logic                  i_clr_vld;
   logic [IW-1:0]         i_clr_port;
   logic [IW-1:0]         o_port;
   logic [PW-1:0]         o_prio;
   logic                  o_port_vld;
   logic                  i_port_rdy;
   logic                  o_empty;
   modport master (
      output i_pending, i_prior, i_update, i_clr_vld, i_clr_port, i_port_rdy,
      input  o_port, o_prio, o_port_vld, o_empty
   );
   modport slave (
      input  i_pending, i_prior, i_update, i_clr_vld, i_clr_port, i_port_rdy,
      output o_port, o_prio, o_port_vld, o_empty
   );
endinterface

// File: rtl/prio_rr_scheduler.sv
// prio_rr_scheduler: strict-priority, per-level round-robin grant scheduler over a pending snapshot
module prio_rr_scheduler #(
   parameter int PORTNUM = 16,
   parameter int PRIOR   = 8
) (
   input logic                 i_clk,
   input logic                 i_rst,
   prio_rr_scheduler_if.slave  bus
);
   localparam int IW = $clog2(PORTNUM);
   localparam int PW = $clog2(PRIOR);
   logic [PORTNUM-1:0] pend_q, pend_d, eff_pend, acc_oh, clr_oh;
   logic [PW-1:0]      prio_q [PORTNUM];
   logic [PW-1:0]      prio_d [PORTNUM];
   logic [IW-1:0]      rr_q [PRIOR];
   logic [IW-1:0]      rr_d [PRIOR];
   logic [IW-1:0]      port_q, port_d, sel, nxt_ptr;
   logic [PW-1:0]      oprio_q, oprio_d, lvl, acc_lvl;
   logic               vld_q, vld_d, accept, sel_vld, load, found;
   int                 idx;
   // Out-of-range priority values collapse onto the top level
   function automatic logic [PW-1:0] clamp(input logic [PW-1:0] v);
      return (int'(v) >= PRIOR) ? PW'(PRIOR - 1) : v;
   endfunction
   always_comb begin
      accept   = vld_q & bus.i_port_rdy;
      acc_oh   = accept ? (PORTNUM'(1) << port_q) : '0;
      clr_oh   = bus.i_clr_vld ? (PORTNUM'(1) << bus.i_clr_port) : '0;
      eff_pend = pend_q & ~acc_oh;
      acc_lvl  = clamp(oprio_q);
      nxt_ptr  = (int'(port_q) == PORTNUM - 1) ? '0 : port_q + 1'b1;
      rr_d     = rr_q;
      if (accept) rr_d[acc_lvl] = nxt_ptr;
      lvl = '0;
      for (int l = 0; l < PRIOR; l++)
         for (int p = 0; p < PORTNUM; p++)
            if (eff_pend[p] && clamp(prio_q[p]) == PW'(l)) lvl = PW'(l);
      sel   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < PORTNUM; i++) begin
         idx = (int'(rr_d[lvl]) + i) % PORTNUM;
         if (!found && eff_pend[idx] && clamp(prio_q[idx]) == lvl) begin
            found = 1'b1;
            sel   = IW'(idx);
         end
      end
      sel_vld = |eff_pend;
      pend_d  = bus.i_update ? bus.i_pending : (pend_q & ~clr_oh & ~acc_oh);
      for (int p = 0; p < PORTNUM; p++)
         prio_d[p] = bus.i_update ? bus.i_prior[p*PW +: PW] : prio_q[p];
      // A held offer is a committed grant: only reload when idle or accepted
      load    = !vld_q || accept;
      port_d  = load ? sel : port_q;
      oprio_d = load ? prio_q[sel] : oprio_q;
      vld_d   = load ? sel_vld : vld_q;
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pend_q  <= '0;
         prio_q  <= '{default: '0};
         rr_q    <= '{default: '0};
         port_q  <= '0;
         oprio_q <= '0;
         vld_q   <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         prio_q  <= prio_d;
         rr_q    <= rr_d;
         port_q  <= port_d;
         oprio_q <= oprio_d;
         vld_q   <= vld_d;
      end
   end
   assign bus.o_port     = port_q;
   assign bus.o_prio     = oprio_q;
   assign bus.o_port_vld = vld_q;
   assign bus.o_empty    = ~|pend_q;
endmodule

// File: tb/tb_prio_rr_scheduler.sv
// tb_prio_rr_scheduler: directed scoreboard bench for prio_rr_scheduler
module tb_prio_rr_scheduler;
   localparam int PORTNUM = 16;
   localparam int PRIOR   = 8;
   localparam int PW      = 3;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   exp_port_q[$];
   int   exp_prio_q[$];
   prio_rr_scheduler_if #(.PORTNUM(PORTNUM), .PRIOR(PRIOR)) bus ();
   prio_rr_scheduler #(.PORTNUM(PORTNUM), .PRIOR(PRIOR)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [PORTNUM*PW-1:0] prio_all(input int v);
      logic [PORTNUM*PW-1:0] r;
      for (int p = 0; p < PORTNUM; p++) r[p*PW +: PW] = PW'(v);
      return r;
   endfunction
   task automatic push(input int p, input int pr);
      exp_port_q.push_back(p);
      exp_prio_q.push_back(pr);
   endtask
   task automatic load(input logic [PORTNUM-1:0] pend, input logic [PORTNUM*PW-1:0] pr);
      bus.i_pending = pend;
      bus.i_prior   = pr;
      bus.i_update  = 1'b1;
      step();
      bus.i_update  = 1'b0;
   endtask
   task automatic drain(input string tag);
      int budget = 0;
      while (exp_port_q.size() > 0 && budget < 40) begin
         if (bus.o_port_vld && bus.i_port_rdy) begin
            chk({tag, " port"}, 32'(bus.o_port), exp_port_q.pop_front());
            chk({tag, " prio"}, 32'(bus.o_prio), exp_prio_q.pop_front());
            if (exp_port_q.size() == 0) break;
         end
         step();
         budget++;
      end
      chk({tag, " drained"}, exp_port_q.size(), 0);
      exp_port_q.delete();
      exp_prio_q.delete();
   endtask
   task automatic idle_check(input string tag);
      chk({tag, " vld"}, 32'(bus.o_port_vld), 0);
      chk({tag, " empty"}, 32'(bus.o_empty), 1);
   endtask
   task automatic flush(input string tag);
      bus.i_port_rdy = 1'b1;
      load('0, '0);
      repeat (4) step();
      idle_check(tag);
   endtask
   initial begin
      bus.i_pending  = '0;
      bus.i_prior    = '0;
      bus.i_update   = 1'b0;
      bus.i_clr_vld  = 1'b0;
      bus.i_clr_port = '0;
      bus.i_port_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset vld", 32'(bus.o_port_vld), 0);
      chk("reset port", 32'(bus.o_port), 0);
      chk("reset prio", 32'(bus.o_prio), 0);
      chk("reset empty", 32'(bus.o_empty), 1);
      // Empty snapshot never produces an offer
      load('0, '0);
      repeat (2) step();
      idle_check("empty update");
      // Strict priority across levels
      bus.i_port_rdy = 1'b1;
      load(16'h0016, (48'(3) << 3) | (48'(7) << 6) | (48'(3) << 12));
      push(2, 7);
      push(1, 3);
      push(4, 3);
      drain("strict");
      step();
      idle_check("strict end");
      // Round robin within one level, resumed across a fresh snapshot
      load(16'hFFFF, prio_all(5));
      for (int i = 0; i <= 5; i++) push(i, 5);
      drain("rr first");
      step();
      bus.i_port_rdy = 1'b0;
      chk("rr held port", 32'(bus.o_port), 6);
      load(16'hFFFF, prio_all(5));
      for (int i = 6; i < PORTNUM; i++) push(i, 5);
      push(0, 5);
      push(1, 5);
      bus.i_port_rdy = 1'b1;
      drain("rr wrap");
      flush("rr flush");
      // Backpressure: a held offer survives clears and updates
      bus.i_port_rdy = 1'b0;
      load(16'h0088, prio_all(1));
      step();
      chk("bp first port", 32'(bus.o_port), 3);
      chk("bp first vld", 32'(bus.o_port_vld), 1);
      for (int i = 0; i < 10; i++) begin
         if (i == 2) begin
            bus.i_clr_vld  = 1'b1;
            bus.i_clr_port = 4'd3;
         end
         if (i == 5) begin
            bus.i_pending = 16'h0C00;
            bus.i_prior   = prio_all(1);
            bus.i_update  = 1'b1;
         end
         step();
         bus.i_clr_vld = 1'b0;
         bus.i_update  = 1'b0;
         chk("bp hold port", 32'(bus.o_port), 3);
         chk("bp hold vld", 32'(bus.o_port_vld), 1);
      end
      bus.i_port_rdy = 1'b1;
      push(3, 1);
      push(10, 1);
      push(11, 1);
      drain("bp release");
      step();
      idle_check("bp end");
      // Accept plus clear in one cycle: both flags gone, committed offer still shown
      bus.i_port_rdy = 1'b0;
      load(16'h0220, (48'(3) << 15) | (48'(2) << 27));
      step();
      chk("sim first port", 32'(bus.o_port), 5);
      chk("sim first prio", 32'(bus.o_prio), 3);
      bus.i_port_rdy = 1'b1;
      bus.i_clr_vld  = 1'b1;
      bus.i_clr_port = 4'd9;
      step();
      bus.i_clr_vld  = 1'b0;
      bus.i_port_rdy = 1'b0;
      chk("sim clr port", 32'(bus.o_port), 9);
      chk("sim clr vld", 32'(bus.o_port_vld), 1);
      chk("sim clr empty", 32'(bus.o_empty), 1);
      bus.i_port_rdy = 1'b1;
      step();
      bus.i_port_rdy = 1'b0;
      chk("sim clr done", 32'(bus.o_port_vld), 0);
      // Accept plus update in one cycle: update wins, port re-offered next cycle
      load(16'h0020, 48'(2) << 15);
      step();
      chk("sim upd port", 32'(bus.o_port), 5);
      bus.i_port_rdy = 1'b1;
      bus.i_pending  = 16'h0020;
      bus.i_update   = 1'b1;
      step();
      bus.i_update   = 1'b0;
      bus.i_port_rdy = 1'b0;
      chk("sim upd gap vld", 32'(bus.o_port_vld), 0);
      chk("sim upd gap empty", 32'(bus.o_empty), 0);
      step();
      chk("sim upd reoffer vld", 32'(bus.o_port_vld), 1);
      chk("sim upd reoffer port", 32'(bus.o_port), 5);
      chk("sim upd reoffer prio", 32'(bus.o_prio), 2);
      // Asynchronous reset mid-offer; level-2 pointer must restart at 0
      #2 rst = 1'b1;
      #1;
      chk("arst vld", 32'(bus.o_port_vld), 0);
      chk("arst port", 32'(bus.o_port), 0);
      chk("arst prio", 32'(bus.o_prio), 0);
      chk("arst empty", 32'(bus.o_empty), 1);
      #1 rst = 1'b0;
      bus.i_port_rdy = 1'b1;
      load(16'hFFFF, prio_all(2));
      push(0, 2);
      push(1, 2);
      push(2, 2);
      drain("arst restart");
      flush("arst flush");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
